// File: rtl/mpsoc_msi_ahb3_slave_port.sv
// AHB3 slave-side arbiter/mux: priority arbitration among MASTERS, one-cycle grant, wait states freeze ownership.
// Optional MPSOC_MSI_AHB3_ROUND_ROBIN_EN rotates equal-priority ties; default build resolves ties to the lowest index.
module mpsoc_msi_ahb3_slave_port #(
   parameter int PLEN    = 64,
   parameter int XLEN    = 64,
   parameter int MASTERS = 5
) (
   input  logic                          HCLK,
   input  logic                          HRESET,
   input  logic [MASTERS-1:0][2:0]       mstpriority,
   input  logic [MASTERS-1:0]            mstHSEL,
   input  logic [MASTERS-1:0][PLEN-1:0]  mstHADDR,
   input  logic [MASTERS-1:0][XLEN-1:0]  mstHWDATA,
   input  logic [MASTERS-1:0]            mstHWRITE,
   input  logic [MASTERS-1:0][2:0]       mstHSIZE,
   input  logic [MASTERS-1:0][2:0]       mstHBURST,
   input  logic [MASTERS-1:0][3:0]       mstHPROT,
   input  logic [MASTERS-1:0][1:0]       mstHTRANS,
   input  logic [MASTERS-1:0]            mstHMASTLOCK,
   input  logic [MASTERS-1:0]            mstHREADY,
   input  logic [MASTERS-1:0]            can_switch,
   output logic [MASTERS-1:0]            master_granted,
   output logic [XLEN-1:0]               mstHRDATA,
   output logic [MASTERS-1:0]            mstHREADYOUT,
   output logic [MASTERS-1:0]            mstHRESP,
   output logic                          slvHSEL,
   output logic [PLEN-1:0]               slvHADDR,
   output logic [XLEN-1:0]               slvHWDATA,
   output logic                          slvHWRITE,
   output logic [2:0]                    slvHSIZE,
   output logic [2:0]                    slvHBURST,
   output logic [3:0]                    slvHPROT,
   output logic [1:0]                    slvHTRANS,
   output logic                          slvHMASTLOCK,
   output logic                          slvHREADY,
   input  logic [XLEN-1:0]               slvHRDATA,
   input  logic                          slvHREADYOUT,
   input  logic                          slvHRESP
);
   localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

   typedef enum logic {S_IDLE, S_OWNED} state_t;

   state_t             state_q, state_d;
   logic [MASTERS-1:0] gnt_q, gnt_d, dgnt_q;
   logic [MASTERS-1:0] req, win;
   logic [IW-1:0]      best_idx;
   logic [2:0]         best_prio;
   logic               found, upd;

   always_comb begin
      for (int i = 0; i < MASTERS; i++)
         req[i] = mstHSEL[i] & (mstHTRANS[i] != 2'b00);
   end

`ifdef MPSOC_MSI_AHB3_ROUND_ROBIN_EN
   // ptr_q holds the index where the tie search starts: one past the last grant.
   logic [IW-1:0] ptr_q;

   always_comb begin
      int j;
      best_idx  = '0;
      best_prio = '0;
      found     = 1'b0;
      j         = 0;
      for (int k = 0; k < MASTERS; k++) begin
         j = int'(ptr_q) + k;
         if (j >= MASTERS) j = j - MASTERS;
         if (req[j] && (!found || mstpriority[j] > best_prio)) begin
            found     = 1'b1;
            best_idx  = IW'(j);
            best_prio = mstpriority[j];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET)
         ptr_q <= '0;
      else if (upd && found)
         ptr_q <= (int'(best_idx) == MASTERS - 1) ? '0 : best_idx + 1'b1;
   end
`else
   always_comb begin
      best_idx  = '0;
      best_prio = '0;
      found     = 1'b0;
      for (int i = 0; i < MASTERS; i++) begin
         if (req[i] && (!found || mstpriority[i] > best_prio)) begin
            found     = 1'b1;
            best_idx  = IW'(i);
            best_prio = mstpriority[i];
         end
      end
   end
`endif

   assign win = found ? (MASTERS'(1) << best_idx) : '0;

   // A locked owner holds can_switch low, so lock needs no separate gating here.
   assign upd = slvHREADYOUT & ((state_q == S_IDLE) | (|(gnt_q & can_switch)));

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      if (upd) begin
         gnt_d   = win;
         state_d = found ? S_OWNED : S_IDLE;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         dgnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         if (slvHREADYOUT)
            dgnt_q <= gnt_q & req;
      end
   end

   assign master_granted = gnt_q;

   always_comb begin
      slvHSEL      = 1'b0;
      slvHADDR     = '0;
      slvHWRITE    = 1'b0;
      slvHSIZE     = '0;
      slvHBURST    = '0;
      slvHPROT     = '0;
      slvHTRANS    = 2'b00;
      slvHMASTLOCK = 1'b0;
      for (int i = 0; i < MASTERS; i++) begin
         if (gnt_q[i]) begin
            slvHSEL      = mstHSEL[i];
            slvHADDR     = mstHADDR[i];
            slvHWRITE    = mstHWRITE[i];
            slvHSIZE     = mstHSIZE[i];
            slvHBURST    = mstHBURST[i];
            slvHPROT     = mstHPROT[i];
            slvHTRANS    = mstHTRANS[i];
            slvHMASTLOCK = mstHMASTLOCK[i];
         end
      end
   end

   always_comb begin
      slvHWDATA = '0;
      slvHREADY = slvHREADYOUT;
      for (int i = 0; i < MASTERS; i++) begin
         if (dgnt_q[i]) begin
            slvHWDATA = mstHWDATA[i];
            slvHREADY = mstHREADY[i];
         end
      end
   end

   assign mstHRDATA    = slvHRDATA;
   assign mstHREADYOUT = {MASTERS{slvHREADYOUT}};
   assign mstHRESP     = dgnt_q & {MASTERS{slvHRESP}};

endmodule

// File: tb/tb_mpsoc_msi_ahb3_slave_port.sv
// Directed bench for mpsoc_msi_ahb3_slave_port: arbitration vector table plus hold, wait, tie and error sequences.
module tb_mpsoc_msi_ahb3_slave_port;
   localparam int PLEN = 64, XLEN = 64, M = 5;

   logic                   HCLK = 1'b0, HRESET = 1'b1;
   logic [M-1:0][2:0]      mstpriority;
   logic [M-1:0]           mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY, can_switch;
   logic [M-1:0][PLEN-1:0] mstHADDR;
   logic [M-1:0][XLEN-1:0] mstHWDATA;
   logic [M-1:0][2:0]      mstHSIZE, mstHBURST;
   logic [M-1:0][3:0]      mstHPROT;
   logic [M-1:0][1:0]      mstHTRANS;
   logic [M-1:0]           master_granted, mstHREADYOUT, mstHRESP;
   logic [XLEN-1:0]        mstHRDATA, slvHWDATA, slvHRDATA;
   logic [PLEN-1:0]        slvHADDR;
   logic                   slvHSEL, slvHWRITE, slvHMASTLOCK, slvHREADY, slvHREADYOUT, slvHRESP;
   logic [2:0]             slvHSIZE, slvHBURST;
   logic [3:0]             slvHPROT;
   logic [1:0]             slvHTRANS;

   int errors = 0, checks = 0;

   mpsoc_msi_ahb3_slave_port #(.PLEN(PLEN), .XLEN(XLEN), .MASTERS(M)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .mstpriority(mstpriority),
      .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE),
      .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
      .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY), .can_switch(can_switch),
      .master_granted(master_granted), .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT),
      .mstHRESP(mstHRESP), .slvHSEL(slvHSEL), .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA),
      .slvHWRITE(slvHWRITE), .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST), .slvHPROT(slvHPROT),
      .slvHTRANS(slvHTRANS), .slvHMASTLOCK(slvHMASTLOCK), .slvHREADY(slvHREADY),
      .slvHRDATA(slvHRDATA), .slvHREADYOUT(slvHREADYOUT), .slvHRESP(slvHRESP)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [4:0]  req;
      logic [4:0]  idl;
      logic [14:0] prio;
      logic [4:0]  exp;
   } vec_t;

   vec_t vecs[9];

   function automatic logic [63:0] addr_of(input int m);
      return 64'h1000_0000_0000 + 64'(m) * 64'h100;
   endfunction

   function automatic logic [63:0] wdata_of(input int m);
      return 64'hD0D0_0000_0000_0000 + 64'(m);
   endfunction

   function automatic int oh_idx(input logic [4:0] v);
      int r = 0;
      for (int i = 0; i < M; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input logic [4:0] r, input logic [4:0] idl);
      for (int m = 0; m < M; m++) begin
         mstHSEL[m]   = r[m] | idl[m];
         mstHTRANS[m] = r[m] ? 2'b10 : 2'b00;
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic do_reset();
      HRESET       = 1'b1;
      set_req(5'b0, 5'b0);
      mstpriority  = '0;
      mstHMASTLOCK = '0;
      mstHREADY    = '1;
      can_switch   = '1;
      slvHREADYOUT = 1'b1;
      slvHRESP     = 1'b0;
      for (int m = 0; m < M; m++) mstHBURST[m] = 3'b000;
      tick();
      HRESET = 1'b0;
   endtask

   initial begin
      for (int m = 0; m < M; m++) begin
         mstHADDR[m]  = addr_of(m);
         mstHWDATA[m] = wdata_of(m);
         mstHWRITE[m] = m[0];
         mstHSIZE[m]  = 3'd3;
         mstHBURST[m] = 3'd0;
         mstHPROT[m]  = 4'h3;
      end
      mstpriority = '0; mstHMASTLOCK = '0; mstHREADY = '1; can_switch = '1;
      slvHREADYOUT = 1'b1; slvHRESP = 1'b1; slvHRDATA = 64'h0123_4567_89AB_CDEF;

      // Reset with every master requesting.
      set_req(5'b11111, 5'b0);
      HRESET = 1'b1;
      repeat (2) tick();
      chk("rst_gnt",    64'(master_granted), 64'h0);
      chk("rst_htrans", 64'(slvHTRANS), 64'h0);
      chk("rst_hsel",   64'(slvHSEL), 64'h0);
      chk("rst_hwdata", slvHWDATA, 64'h0);
      chk("rst_hresp",  64'(mstHRESP), 64'h0);
      chk("rst_hready", 64'(slvHREADY), 64'h1);
      HRESET = 1'b0;

      vecs[0] = '{5'b01010, 5'b00000, {3'd0, 3'd5, 3'd0, 3'd2, 3'd0}, 5'b01000};
      vecs[1] = '{5'b00000, 5'b00000, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 5'b00000};
      vecs[2] = '{5'b11111, 5'b00000, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 5'b00001};
      vecs[3] = '{5'b10001, 5'b00000, {3'd7, 3'd0, 3'd0, 3'd0, 3'd1}, 5'b10000};
      vecs[4] = '{5'b00110, 5'b00000, {3'd0, 3'd0, 3'd4, 3'd4, 3'd0}, 5'b00010};
      vecs[5] = '{5'b11100, 5'b00000, {3'd6, 3'd6, 3'd1, 3'd0, 3'd0}, 5'b01000};
      vecs[6] = '{5'b00001, 5'b00000, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, 5'b00001};
      vecs[7] = '{5'b00000, 5'b00100, {3'd0, 3'd0, 3'd7, 3'd0, 3'd0}, 5'b00000};
      vecs[8] = '{5'b00010, 5'b10000, {3'd7, 3'd0, 3'd0, 3'd0, 3'd0}, 5'b00010};

      for (int v = 0; v < 9; v++) begin
         do_reset();
         set_req(vecs[v].req, vecs[v].idl);
         mstpriority = vecs[v].prio;
         tick();
         chk($sformatf("vec%0d_gnt", v), 64'(master_granted), 64'(vecs[v].exp));
         chk($sformatf("vec%0d_hsel", v), 64'(slvHSEL), 64'(vecs[v].exp != 0));
         chk($sformatf("vec%0d_haddr", v), slvHADDR,
             (vecs[v].exp != 0) ? addr_of(oh_idx(vecs[v].exp)) : 64'h0);
         chk($sformatf("vec%0d_htrans", v), 64'(slvHTRANS), (vecs[v].exp != 0) ? 64'h2 : 64'h0);
      end

      // Locked INCR4 owner m0 keeps the bus until it allows a switch.
      do_reset();
      set_req(5'b00001, 5'b0);
      mstHBURST[0] = 3'b011; mstHMASTLOCK[0] = 1'b1; can_switch = 5'b11110;
      mstpriority = {3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
      tick();
      chk("hold_first", 64'(master_granted), 64'h01);
      set_req(5'b10001, 5'b0);
      mstHTRANS[0] = 2'b11;
      mstpriority = {3'd7, 3'd0, 3'd0, 3'd0, 3'd1};
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("hold_c%0d", c), 64'(master_granted), 64'h01);
      end
      chk("hold_burst", 64'(slvHBURST), 64'h3);
      chk("hold_lock",  64'(slvHMASTLOCK), 64'h1);
      chk("hold_trans", 64'(slvHTRANS), 64'h3);
      can_switch = '1;
      tick();
      chk("hold_switch", 64'(master_granted), 64'h10);
      chk("hold_addr",   slvHADDR, addr_of(4));

      // Wait states during m2 data phase.
      do_reset();
      set_req(5'b00100, 5'b0);
      tick();
      tick();
      chk("wait_hwdata0", slvHWDATA, wdata_of(2));
      mstHREADY[2] = 1'b0;
      #1;
      chk("wait_hready_m2", 64'(slvHREADY), 64'h0);
      mstHREADY[2] = 1'b1;
      slvHREADYOUT = 1'b0; slvHRESP = 1'b1;
      set_req(5'b00101, 5'b0);
      mstpriority = {3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
      #1;
      chk("wait_readyout", 64'(mstHREADYOUT), 64'h0);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk($sformatf("wait_gnt%0d", c),  64'(master_granted), 64'h04);
         chk($sformatf("wait_dgnt%0d", c), 64'(mstHRESP), 64'h04);
         chk($sformatf("wait_wd%0d", c),   slvHWDATA, wdata_of(2));
      end
      slvHREADYOUT = 1'b1; slvHRESP = 1'b0;
      tick();
      chk("wait_release", 64'(master_granted), 64'h01);
      chk("wait_readyout1", 64'(mstHREADYOUT), 64'h1F);

      // Equal-priority ties with continuous requests.
      do_reset();
      set_req(5'b00111, 5'b0);
      mstpriority = {3'd0, 3'd0, 3'd3, 3'd3, 3'd3};
      for (int c = 0; c < 4; c++) begin
         tick();
`ifdef MPSOC_MSI_AHB3_ROUND_ROBIN_EN
         chk($sformatf("tie%0d", c), 64'(master_granted), 64'(5'b00001 << (c % 3)));
`else
         chk($sformatf("tie%0d", c), 64'(master_granted), 64'h01);
`endif
      end

      // Error response in m1 data phase, then release handed straight to m3.
      do_reset();
      set_req(5'b00010, 5'b0);
      tick();
      chk("err_gnt", 64'(master_granted), 64'h02);
      tick();
      slvHRESP = 1'b1;
      slvHRDATA = 64'hCAFE_F00D_1234_5678;
      #1;
      chk("err_hresp", 64'(mstHRESP), 64'h02);
      chk("err_rdata", mstHRDATA, 64'hCAFE_F00D_1234_5678);
      set_req(5'b01000, 5'b0);
      tick();
      chk("handoff_gnt", 64'(master_granted), 64'h08);
      chk("handoff_dgnt", 64'(mstHRESP), 64'h00);
      tick();
      chk("handoff_resp", 64'(mstHRESP), 64'h08);

      // Reset mid-transfer abandons ownership.
      HRESET = 1'b1;
      tick();
      chk("midrst_gnt", 64'(master_granted), 64'h0);
      chk("midrst_resp", 64'(mstHRESP), 64'h0);
      HRESET = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mpsoc_msi_ahb3_slave_port.md
MPSOC_MSI_AHB3_SLAVE_PORT -- requirements
Module: mpsoc_msi_ahb3_slave_port

Interface
REQ-001 Parameters SHALL be: PLEN, 64, address width; XLEN, 64, data width; MASTERS, 5, number of master ports arbitrating for this slave.
REQ-002 HCLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 HRESET  in  1  reset, synchronous, active-high.
REQ-004 mstpriority  in  MASTERS x 3  per-master priority; higher value wins.
REQ-005 mstHSEL, mstHWRITE, mstHMASTLOCK  in  MASTERS x 1 each  per-master AHB address-phase controls.
REQ-006 mstHADDR  in  MASTERS x PLEN;  mstHWDATA  in  MASTERS x XLEN;  mstHSIZE, mstHBURST  in  MASTERS x 3;  mstHPROT  in  MASTERS x 4;  mstHTRANS  in  MASTERS x 2.
REQ-007 mstHREADY  in  MASTERS  per-master transfer-advance indication.
REQ-008 can_switch  in  MASTERS  master port permits ownership change on the next cycle.
REQ-009 master_granted  out  MASTERS  one-hot address-phase grant.
REQ-010 mstHRDATA  out  XLEN;  mstHREADYOUT  out  MASTERS;  mstHRESP  out  MASTERS.
REQ-011 slvHSEL, slvHWRITE, slvHMASTLOCK, slvHREADY  out  1;  slvHADDR  out  PLEN;  slvHWDATA  out  XLEN;  slvHSIZE, slvHBURST  out  3;  slvHPROT  out  4;  slvHTRANS  out  2.
REQ-012 slvHRDATA  in  XLEN;  slvHREADYOUT  in  1;  slvHRESP  in  1.

Function
REQ-013 Request from master m SHALL be mstHSEL[m] & (mstHTRANS[m] != IDLE).
REQ-014 Arbitration winner SHALL be the requester with the highest mstpriority; ties resolved per REQ-029.
REQ-015 Address owner register gnt (one-hot or zero) SHALL update only when slvHREADYOUT=1 and (gnt=0 or can_switch[owner]=1); otherwise gnt SHALL hold.
REQ-016 On update, gnt SHALL load the winner; with no requesters gnt SHALL load 0.
REQ-017 master_granted SHALL equal gnt; grant latency one cycle after request for an idle slave.
REQ-018 FSM states IDLE (gnt=0) and OWNED (gnt!=0); IDLE->OWNED on update with a requester; OWNED->IDLE on update with none; OWNED->OWNED re-arbitrates on every permitted update.
REQ-019 In OWNED, slvHADDR/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HSEL/HTRANS SHALL be the owner's inputs, combinationally muxed; in IDLE slvHSEL=0, slvHTRANS=IDLE, other address outputs 0.
REQ-020 Data-phase owner register dgnt SHALL load gnt & request-of-owner when slvHREADYOUT=1, else hold.
REQ-021 slvHWDATA SHALL be mstHWDATA of the dgnt owner, 0 when dgnt=0.
REQ-022 slvHREADY SHALL be mstHREADY[dgnt owner] when dgnt!=0, else slvHREADYOUT.
REQ-023 mstHRDATA SHALL broadcast slvHRDATA; mstHREADYOUT[m] SHALL equal slvHREADYOUT for all m.
REQ-024 mstHRESP[m] SHALL be slvHRESP when dgnt[m]=1, else OKAY.
REQ-025 While the owner asserts mstHMASTLOCK with can_switch=0, no other master SHALL be granted regardless of priority.
REQ-026 Simultaneous owner release and new request SHALL produce the new grant in the same update, without an IDLE cycle.
REQ-027 slvHREADYOUT=0 SHALL freeze gnt, dgnt and the tie-break pointer.

Reset
REQ-028 On HRESET=1 at a clock edge: gnt=0, dgnt=0, tie-break pointer=0, FSM=IDLE; hence master_granted=0, slvHSEL=0, slvHTRANS=IDLE, slvHWDATA=0, mstHRESP=OKAY; reset mid-transfer abandons the transfer.

Configuration
REQ-029 Macro MPSOC_MSI_AHB3_ROUND_ROBIN_EN: defined -> equal-priority ties go to the first requester after the last granted index (wrapping MASTERS-1 to 0), pointer updated on each grant; undefined -> ties go to the lowest index, no pointer register.

Verification
REQ-030 Reset: HRESET=1 for 2 cycles with all requesting -> master_granted=0, slvHTRANS=IDLE, slvHSEL=0.
REQ-031 Priority: m1 prio 2, m3 prio 5 request NONSEQ SINGLE from IDLE -> master_granted=5'b01000 next cycle, slvHADDR=mstHADDR[3].
REQ-032 Hold: owner m0 INCR4, can_switch[0]=0 for 3 cycles, m4 prio 7 requesting -> gnt stays m0; can_switch[0]=1 -> m4 granted next edge.
REQ-033 Wait state: slvHREADYOUT=0 for 2 cycles in m2 data phase -> gnt/dgnt frozen, mstHREADYOUT all 0, slvHWDATA=mstHWDATA[2].
REQ-034 Tie (macro defined): m0, m1, m2 prio 3, permanently requesting, can_switch=1 -> grants m0,m1,m2,m0; undefined -> m0 every cycle.
REQ-035 Error: slvHRESP=1 in m1 data phase -> mstHRESP=5'b00010, others OKAY.
